fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that drives the instruction-memory address and consumes its 32-bit read data.
- Holds the PC and selects the next PC from sequential, branch, exception-vector and ERET-return sources.
- Registers the fetched word into an IF/ID register for decode.
- Detects out-of-range or misaligned fetches and holds in a fault state until an exception redirect arrives.

Parameters:
- N, 64, PC and target width in bits.
- IMEM_AW, 6, instruction-memory word-address width; fetch window is 4*2^IMEM_AW bytes (256 by default).
- EXC_VECTOR, 64'hC0, byte address loaded into the PC on exc_req.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  N  branch byte address.
- exc_req  in  1  redirect to EXC_VECTOR.
- eret  in  1  redirect to elr.
- elr  in  N  exception return byte address.
- imem_q  in  32  instruction word from instruction memory (combinational read).
- imem_addr  out  IMEM_AW  word address, equal to pc[IMEM_AW+1:2].
- pc_out  out  N  current PC.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  N  PC of if_id_instr.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_fault  out  1  high while in FAULT.
- fault_pc  out  N  PC that caused the fault.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=0, if_id_instr=0, if_id_pc=0, if_id_valid=0, fault_pc=0, state=RUN, fetch_fault=0.
  - Asserting reset mid-operation clears all of the above immediately; the first edge after release fetches address 0.
- imem_addr is purely combinational from pc; there are no added cycles. Instruction latency is one edge from PC to IF/ID.
- bad_pc (combinational) = pc[1:0]!=0 OR pc[N-1:IMEM_AW+2]!=0.
- States:
  - RUN: normal fetch.
  - FAULT: PC frozen; fetch_fault=1.
- Per-edge priority (highest first):
  1. exc_req: pc<=EXC_VECTOR; if_id_valid<=0; if_id_instr<=0; state<=RUN. Valid in any state.
  2. eret (RUN only): pc<=elr; squash IF/ID as above.
  3. branch_taken (RUN only): pc<=branch_target; squash IF/ID.
  4. RUN and bad_pc: state<=FAULT; fault_pc<=pc; squash IF/ID; pc holds.
  5. stall (RUN only): pc, IF/ID and fault_pc all hold.
  6. RUN otherwise:
     - if_id_instr<=imem_q; if_id_pc<=pc; if_id_valid<=1.
     - pc<=pc+4, computed modulo 2^N (wraps at all-ones).
- Redirects override stall. Simultaneous requests resolve strictly by the priority order above.
- In FAULT, eret, branch_taken and stall are ignored. Only exc_req or reset leaves FAULT.
- Sequential wrap: pc=0xFC fetches normally. The next pc is 0x100, which faults on the following edge; no word beyond the window is ever registered.
- A misaligned branch_target or elr is accepted into pc and faults on the next edge.
- If EXC_VECTOR itself is bad_pc, the block faults again after the redirect. This is a legal loop and needs no special handling.
- fault_pc updates only on entry to FAULT.

Test Plan:
- Reset then release, imem loaded with the standard program:
  - Edge 1: if_id_instr=f8000001, if_id_pc=0, valid=1.
  - Edge 2: if_id_instr=f8008002, if_id_pc=4.
  - imem_addr walks 0,1,2…
- stall=1 for 3 edges at pc=0x0C: pc_out stays 0x0C and if_id_instr stays f8000203. After release the next word registered is 8b050083.
- branch_taken=1 with target=0x74 and stall=1 on the same edge:
  - That edge: valid=0, instr=0, pc=0x74.
  - Next edge: if_id_instr=b4000040, if_id_pc=0x74.
- Run sequentially to pc=0xFC, then to 0x100:
  - fetch_fault=1, fault_pc=0x100, valid=0.
  - pc holds for 5 edges despite branch_taken and eret.
  - exc_req then gives pc=0xC0 and fetch_fault=0.
  - The next edge registers imem word 48 with valid=1.
- exc_req, eret (elr=0x20) and branch_taken all on one edge: pc=0xC0. Then eret alone gives pc=0x20, and the next edge registers f8020003.
- Assert reset asynchronously between edges at pc=0x40: all outputs zero immediately, without a clock edge. After release, the first fetch is f8000001.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, selects the next PC from sequential,
// branch, exception-vector and ERET sources, and registers the fetched word
// into the IF/ID register. Out-of-window or misaligned PCs park the stage in
// FAULT until an exception redirect arrives.
module fetch_unit #(
   parameter int unsigned   N          = 64,
   parameter int unsigned   IMEM_AW    = 6,
   parameter logic [N-1:0]  EXC_VECTOR = 64'hC0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [N-1:0]       branch_target,
   input  logic               exc_req,
   input  logic               eret,
   input  logic [N-1:0]       elr,
   input  logic [31:0]        imem_q,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [N-1:0]       pc_out,
   output logic [31:0]        if_id_instr,
   output logic [N-1:0]       if_id_pc,
   output logic               if_id_valid,
   output logic               fetch_fault,
   output logic [N-1:0]       fault_pc
);

   typedef enum logic {StRun, StFault} state_t;

   state_t       state;
   logic [N-1:0] pc;
   logic         bad_pc;

   // Word address straight from the PC; memory read is combinational.
   assign imem_addr = pc[IMEM_AW+1:2];
   assign pc_out    = pc;

   // Misaligned, or any address bit above the fetch window set.
   always_comb begin
      bad_pc = 1'b0;
      if (pc[1:0] != 2'b00) bad_pc = 1'b1;
      if ((pc >> (IMEM_AW + 2)) != '0) bad_pc = 1'b1;
   end

   // PC, IF/ID and fault FSM; redirects win over stall, exc_req over all.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= StRun;
         pc          <= '0;
         if_id_instr <= '0;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
         fetch_fault <= 1'b0;
         fault_pc    <= '0;
      end else if (exc_req) begin
         state       <= StRun;
         fetch_fault <= 1'b0;
         pc          <= EXC_VECTOR;
         if_id_instr <= '0;
         if_id_valid <= 1'b0;
      end else begin
         unique case (state)
            StRun: begin
               if (eret) begin
                  pc          <= elr;
                  if_id_instr <= '0;
                  if_id_valid <= 1'b0;
               end else if (branch_taken) begin
                  pc          <= branch_target;
                  if_id_instr <= '0;
                  if_id_valid <= 1'b0;
               end else if (bad_pc) begin
                  // PC holds so fault_pc and pc_out both show the culprit.
                  state       <= StFault;
                  fetch_fault <= 1'b1;
                  fault_pc    <= pc;
                  if_id_instr <= '0;
                  if_id_valid <= 1'b0;
               end else if (!stall) begin
                  if_id_instr <= imem_q;
                  if_id_pc    <= pc;
                  if_id_valid <= 1'b1;
                  pc          <= pc + N'(4);
               end
            end
            StFault: begin
               // Frozen: only exc_req (above) or reset leaves this state.
               fetch_fault <= 1'b1;
            end
            default: begin
               state       <= StFault;
               fetch_fault <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: one task per scenario, inline checks.
module tb_fetch_unit;

   localparam int unsigned N       = 64;
   localparam int unsigned IMEM_AW = 6;

   logic               clk;
   logic               reset;
   logic               stall;
   logic               branch_taken;
   logic [N-1:0]       branch_target;
   logic               exc_req;
   logic               eret;
   logic [N-1:0]       elr;
   logic [31:0]        imem_q;
   logic [IMEM_AW-1:0] imem_addr;
   logic [N-1:0]       pc_out;
   logic [31:0]        if_id_instr;
   logic [N-1:0]       if_id_pc;
   logic               if_id_valid;
   logic               fetch_fault;
   logic [N-1:0]       fault_pc;

   logic [31:0] mem [64];

   int n_cmp = 0;
   int n_err = 0;

   fetch_unit #(
      .N          (N),
      .IMEM_AW    (IMEM_AW),
      .EXC_VECTOR (64'hC0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .exc_req       (exc_req),
      .eret          (eret),
      .elr           (elr),
      .imem_q        (imem_q),
      .imem_addr     (imem_addr),
      .pc_out        (pc_out),
      .if_id_instr   (if_id_instr),
      .if_id_pc      (if_id_pc),
      .if_id_valid   (if_id_valid),
      .fetch_fault   (fetch_fault),
      .fault_pc      (fault_pc)
   );

   assign imem_q = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; branch_taken = 0; branch_target = '0;
      exc_req = 0; eret = 0; elr = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      #1;
      n_cmp++; if (pc_out !== 64'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc_out); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
      n_cmp++; if (if_id_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", if_id_instr); end
      n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
      #1;
      reset = 1'b1;
   endtask

   task automatic test_sequential();
      step();
      n_cmp++; if (if_id_instr !== 32'hf8000001) begin n_err++; $display("FAIL seq1_instr: got %h want f8000001", if_id_instr); end
      n_cmp++; if (if_id_pc !== 64'h0) begin n_err++; $display("FAIL seq1_pc: got %h want 0", if_id_pc); end
      n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL seq1_valid: got %b want 1", if_id_valid); end
      n_cmp++; if (imem_addr !== 6'd1) begin n_err++; $display("FAIL seq1_addr: got %0d want 1", imem_addr); end
      step();
      n_cmp++; if (if_id_instr !== 32'hf8008002) begin n_err++; $display("FAIL seq2_instr: got %h want f8008002", if_id_instr); end
      n_cmp++; if (if_id_pc !== 64'h4) begin n_err++; $display("FAIL seq2_pc: got %h want 4", if_id_pc); end
      n_cmp++; if (imem_addr !== 6'd2) begin n_err++; $display("FAIL seq2_addr: got %0d want 2", imem_addr); end
      step();
      n_cmp++; if (pc_out !== 64'h0C) begin n_err++; $display("FAIL seq3_pc: got %h want 0c", pc_out); end
   endtask

   task automatic test_stall();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (pc_out !== 64'h0C) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 0c", i, pc_out); end
         n_cmp++; if (if_id_instr !== 32'hf8000203) begin n_err++; $display("FAIL stall_instr[%0d]: got %h want f8000203", i, if_id_instr); end
      end
      stall = 0;
      step();
      n_cmp++; if (if_id_instr !== 32'h8b050083) begin n_err++; $display("FAIL stall_release_instr: got %h want 8b050083", if_id_instr); end
      n_cmp++; if (if_id_pc !== 64'h0C) begin n_err++; $display("FAIL stall_release_pc: got %h want 0c", if_id_pc); end
   endtask

   task automatic test_branch_over_stall();
      branch_taken = 1; branch_target = 64'h74; stall = 1;
      step();
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL br_valid: got %b want 0", if_id_valid); end
      n_cmp++; if (if_id_instr !== 32'h0) begin n_err++; $display("FAIL br_instr: got %h want 0", if_id_instr); end
      n_cmp++; if (pc_out !== 64'h74) begin n_err++; $display("FAIL br_pc: got %h want 74", pc_out); end
      clear_inputs();
      step();
      n_cmp++; if (if_id_instr !== 32'hb4000040) begin n_err++; $display("FAIL br_next_instr: got %h want b4000040", if_id_instr); end
      n_cmp++; if (if_id_pc !== 64'h74) begin n_err++; $display("FAIL br_next_pc: got %h want 74", if_id_pc); end
   endtask

   task automatic test_wrap_fault();
      for (int i = 0; i < 64 && pc_out !== 64'hFC; i++) step();
      n_cmp++; if (pc_out !== 64'hFC) begin n_err++; $display("FAIL wrap_reach_fc: got %h want fc", pc_out); end
      step();
      n_cmp++; if (if_id_pc !== 64'hFC) begin n_err++; $display("FAIL wrap_fc_pc: got %h want fc", if_id_pc); end
      n_cmp++; if (if_id_instr !== 32'he000003f) begin n_err++; $display("FAIL wrap_fc_instr: got %h want e000003f", if_id_instr); end
      n_cmp++; if (pc_out !== 64'h100) begin n_err++; $display("FAIL wrap_next_pc: got %h want 100", pc_out); end
      n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL wrap_early_fault: got %b want 0", fetch_fault); end
      step();
      n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL fault_flag: got %b want 1", fetch_fault); end
      n_cmp++; if (fault_pc !== 64'h100) begin n_err++; $display("FAIL fault_pc: got %h want 100", fault_pc); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL fault_valid: got %b want 0", if_id_valid); end
      branch_taken = 1; branch_target = 64'h10; eret = 1; elr = 64'h20;
      for (int i = 0; i < 5; i++) begin
         stall = i[0];
         step();
         n_cmp++; if (pc_out !== 64'h100) begin n_err++; $display("FAIL fault_hold_pc[%0d]: got %h want 100", i, pc_out); end
         n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL fault_hold_flag[%0d]: got %b want 1", i, fetch_fault); end
      end
      clear_inputs();
      exc_req = 1;
      step();
      n_cmp++; if (pc_out !== 64'hC0) begin n_err++; $display("FAIL exc_pc: got %h want c0", pc_out); end
      n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL exc_fault: got %b want 0", fetch_fault); end
      n_cmp++; if (fault_pc !== 64'h100) begin n_err++; $display("FAIL exc_fault_pc_hold: got %h want 100", fault_pc); end
      exc_req = 0;
      step();
      n_cmp++; if (if_id_instr !== 32'hd65f03c0) begin n_err++; $display("FAIL exc_fetch_instr: got %h want d65f03c0", if_id_instr); end
      n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL exc_fetch_valid: got %b want 1", if_id_valid); end
   endtask

   task automatic test_priority();
      exc_req = 1; eret = 1; elr = 64'h20; branch_taken = 1; branch_target = 64'h74;
      step();
      n_cmp++; if (pc_out !== 64'hC0) begin n_err++; $display("FAIL prio_all_pc: got %h want c0", pc_out); end
      exc_req = 0;
      step();
      n_cmp++; if (pc_out !== 64'h20) begin n_err++; $display("FAIL prio_eret_pc: got %h want 20", pc_out); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL prio_eret_valid: got %b want 0", if_id_valid); end
      clear_inputs();
      step();
      n_cmp++; if (if_id_instr !== 32'hf8020003) begin n_err++; $display("FAIL prio_eret_instr: got %h want f8020003", if_id_instr); end
      n_cmp++; if (if_id_pc !== 64'h20) begin n_err++; $display("FAIL prio_eret_ifpc: got %h want 20", if_id_pc); end
   endtask

   task automatic test_misaligned();
      branch_taken = 1; branch_target = 64'h22;
      step();
      n_cmp++; if (pc_out !== 64'h22) begin n_err++; $display("FAIL mis_pc: got %h want 22", pc_out); end
      n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL mis_early_fault: got %b want 0", fetch_fault); end
      clear_inputs();
      step();
      n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL mis_fault: got %b want 1", fetch_fault); end
      n_cmp++; if (fault_pc !== 64'h22) begin n_err++; $display("FAIL mis_fault_pc: got %h want 22", fault_pc); end
      exc_req = 1;
      step();
      exc_req = 0;
   endtask

   task automatic test_async_reset();
      branch_taken = 1; branch_target = 64'h30;
      step();
      clear_inputs();
      for (int i = 0; i < 16 && pc_out !== 64'h40; i++) step();
      n_cmp++; if (pc_out !== 64'h40) begin n_err++; $display("FAIL ar_reach_40: got %h want 40", pc_out); end
      #2;
      reset = 0;
      #1;
      n_cmp++; if (pc_out !== 64'h0) begin n_err++; $display("FAIL ar_pc: got %h want 0", pc_out); end
      n_cmp++; if (if_id_instr !== 32'h0) begin n_err++; $display("FAIL ar_instr: got %h want 0", if_id_instr); end
      n_cmp++; if (if_id_pc !== 64'h0) begin n_err++; $display("FAIL ar_ifpc: got %h want 0", if_id_pc); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b want 0", if_id_valid); end
      n_cmp++; if (fault_pc !== 64'h0) begin n_err++; $display("FAIL ar_fault_pc: got %h want 0", fault_pc); end
      n_cmp++; if (imem_addr !== 6'd0) begin n_err++; $display("FAIL ar_addr: got %0d want 0", imem_addr); end
      #2;
      reset = 1;
      step();
      n_cmp++; if (if_id_instr !== 32'hf8000001) begin n_err++; $display("FAIL ar_first_instr: got %h want f8000001", if_id_instr); end
      n_cmp++; if (if_id_pc !== 64'h0) begin n_err++; $display("FAIL ar_first_pc: got %h want 0", if_id_pc); end
      n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL ar_first_valid: got %b want 1", if_id_valid); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'he0000000 | 32'(i);
      mem[0]  = 32'hf8000001;
      mem[1]  = 32'hf8008002;
      mem[2]  = 32'hf8000203;
      mem[3]  = 32'h8b050083;
      mem[8]  = 32'hf8020003;
      mem[29] = 32'hb4000040;
      mem[48] = 32'hd65f03c0;

      test_reset();
      test_sequential();
      test_stall();
      test_branch_over_stall();
      test_wrap_fault();
      test_priority();
      test_misaligned();
      test_async_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
